// File: rtl/hemaia_reset_sequencer.sv
// Power-on and software-requested local reset sequencer: holds the selected
// channels in reset, then releases them one at a time in ascending order.
module hemaia_reset_sequencer #(
  parameter  int unsigned NumReset   = 4,
  parameter  int unsigned HoldCycles = 16,
  parameter  int unsigned GapCycles  = 8,
  localparam int unsigned CntWidth   =
    $clog2(((HoldCycles > GapCycles) ? HoldCycles : GapCycles) + 1)
) (
  input  logic                clk_i,
  input  logic                sync_ff_rst,
  input  logic                req_valid_i,
  input  logic [NumReset-1:0] req_mask_i,
  output logic                req_ready_o,
  output logic [NumReset-1:0] local_rst_no,
  output logic                busy_o,
  output logic                done_o
);

  localparam int unsigned PtrWidth   = (NumReset > 1) ? $clog2(NumReset) : 1;
  localparam int unsigned GapLastInt = (GapCycles > 0) ? GapCycles - 1 : 0;

  localparam logic [CntWidth-1:0] HoldLast = CntWidth'(HoldCycles - 1);
  localparam logic [CntWidth-1:0] GapLast  = CntWidth'(GapLastInt);
  localparam logic [PtrWidth-1:0] PtrLast  = PtrWidth'(NumReset - 1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    GAP     = 2'd2,
    IDLE    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q,   cnt_d;
  logic [PtrWidth-1:0] ptr_q,   ptr_d;
  logic [NumReset-1:0] mask_q,  mask_d;
  logic [NumReset-1:0] rst_q,   rst_d;
  logic                done_q,  done_d;

  // NOTE: every variable gets its hold value before the case statement, so no
  // path through the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    mask_d  = mask_q;
    rst_d   = rst_q;
    done_d  = 1'b0;

    unique case (state_q)
      HOLD: begin
        if (cnt_q == HoldLast) begin
          state_d = RELEASE;
          ptr_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RELEASE: begin
        if (mask_q[ptr_q]) rst_d[ptr_q] = 1'b1;
        if (ptr_q == PtrLast) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (mask_q[ptr_q] && (GapCycles > 0)) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          // Unmasked channels cost a single RELEASE cycle and no gap.
          ptr_d = ptr_q + 1'b1;
        end
      end

      GAP: begin
        if (cnt_q == GapLast) begin
          state_d = RELEASE;
          ptr_d   = ptr_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      IDLE: begin
        if (req_valid_i) begin
          if (req_mask_i == '0) begin
            done_d = 1'b1;
          end else begin
            mask_d  = req_mask_i;
            rst_d   = rst_q & ~req_mask_i;
            state_d = HOLD;
            cnt_d   = '0;
            ptr_d   = '0;
          end
        end
      end

      default: state_d = HOLD;
    endcase
  end

  // NOTE: reset is asynchronous so the local resets drop the moment
  // sync_ff_rst falls, even if clk_i is not yet running; state uses <= only.
  always_ff @(posedge clk_i or negedge sync_ff_rst) begin
    if (!sync_ff_rst) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      ptr_q   <= '0;
      mask_q  <= '1;
      rst_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
    end
  end

  // Local resets come straight from flops so downstream async inputs see no glitches.
  assign local_rst_no = rst_q;
  assign done_o       = done_q;
  assign busy_o       = (state_q != IDLE);
  assign req_ready_o  = (state_q == IDLE);

endmodule

// File: tb/tb_hemaia_reset_sequencer.sv
// Directed bench for hemaia_reset_sequencer: default configuration plus a
// minimal one-channel, no-gap configuration sharing clock and reset.
module tb_hemaia_reset_sequencer;

  logic       clk_i = 1'b0;
  logic       sync_ff_rst = 1'b0;

  logic       d_req_valid = 1'b0;
  logic [3:0] d_req_mask  = '0;
  logic       d_ready, d_busy, d_done;
  logic [3:0] d_rst;

  logic       s_req_valid = 1'b0;
  logic [0:0] s_req_mask  = '0;
  logic       s_ready, s_busy, s_done;
  logic [0:0] s_rst;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  hemaia_reset_sequencer dut_d (
    .clk_i        (clk_i),
    .sync_ff_rst  (sync_ff_rst),
    .req_valid_i  (d_req_valid),
    .req_mask_i   (d_req_mask),
    .req_ready_o  (d_ready),
    .local_rst_no (d_rst),
    .busy_o       (d_busy),
    .done_o       (d_done)
  );

  hemaia_reset_sequencer #(
    .NumReset   (1),
    .HoldCycles (1),
    .GapCycles  (0)
  ) dut_s (
    .clk_i        (clk_i),
    .sync_ff_rst  (sync_ff_rst),
    .req_valid_i  (s_req_valid),
    .req_mask_i   (s_req_mask),
    .req_ready_o  (s_ready),
    .local_rst_no (s_rst),
    .busy_o       (s_busy),
    .done_o       (s_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Boot sequence from reset deassertion; channel k rises at edge 17 + 9k.
  task automatic run_boot(input int last_edge);
    logic [3:0] exp;
    for (int e = 1; e <= last_edge; e++) begin
      tick();
      exp = '0;
      for (int k = 0; k < 4; k++) if (e >= 17 + 9 * k) exp[k] = 1'b1;
      check("boot_rst", 32'(d_rst), 32'(exp));
      check("boot_done", 32'(d_done), 32'(e == 44));
      check("boot_busy", 32'(d_busy), 32'(e < 44));
      check("boot_ready", 32'(d_ready), 32'(e >= 44));
      if (e <= 3) begin
        check("s_boot_rst", 32'(s_rst), 32'(e >= 2));
        check("s_boot_done", 32'(s_done), 32'(e == 2));
        check("s_boot_busy", 32'(s_busy), 32'(e < 2));
      end
    end
  endtask

  task automatic check_reset_values();
    check("rst_local", 32'(d_rst), 32'h0);
    check("rst_busy", 32'(d_busy), 32'h1);
    check("rst_ready", 32'(d_ready), 32'h0);
    check("rst_done", 32'(d_done), 32'h0);
    check("s_rst_local", 32'(s_rst), 32'h0);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!d_done && n < budget) begin
      tick();
      n++;
    end
    if (!d_done) check("done_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    logic [3:0] exp;

    // Reset state, then boot.
    #12;
    check_reset_values();
    @(negedge clk_i);
    sync_ff_rst = 1'b1;
    run_boot(30);

    // Reset pulse at edge 30 drops every channel immediately and restarts boot.
    check("pre_pulse_rst", 32'(d_rst), 32'h3);
    sync_ff_rst = 1'b0;
    #1;
    check_reset_values();
    #1;
    sync_ff_rst = 1'b1;
    run_boot(46);

    // Request 0101: bit 0 at A+17, gap, bit 1 skipped, bit 2 at A+27, gap, bit 3 skipped.
    d_req_valid = 1'b1;
    d_req_mask  = 4'b0101;
    check("req_ready_idle", 32'(d_ready), 32'h1);
    tick();
    d_req_valid = 1'b0;
    d_req_mask  = '0;
    for (int t = 0; t <= 37; t++) begin
      if (t > 0) tick();
      exp = 4'b1010;
      if (t >= 17) exp[0] = 1'b1;
      if (t >= 27) exp[2] = 1'b1;
      check("req5_rst", 32'(d_rst), 32'(exp));
      check("req5_done", 32'(d_done), 32'(t == 36));
      check("req5_busy", 32'(d_busy), 32'(t < 36));
    end

    // Zero mask: done pulse only, nothing disturbed.
    d_req_valid = 1'b1;
    d_req_mask  = 4'b0000;
    check("zero_ready", 32'(d_ready), 32'h1);
    tick();
    d_req_valid = 1'b0;
    check("zero_done", 32'(d_done), 32'h1);
    check("zero_busy", 32'(d_busy), 32'h0);
    check("zero_rst", 32'(d_rst), 32'hf);
    tick();
    check("zero_done_clr", 32'(d_done), 32'h0);
    check("zero_busy2", 32'(d_busy), 32'h0);

    // Valid held across a busy sequence: ignored until IDLE, mask sampled there.
    d_req_valid = 1'b1;
    d_req_mask  = 4'b0001;
    tick();
    d_req_mask  = 4'b0010;
    check("hold_accept_rst", 32'(d_rst), 32'he);
    for (int t = 1; t <= 28; t++) begin
      tick();
      exp = 4'b1110;
      if (t >= 17) exp[0] = 1'b1;
      check("hold_busy_rst", 32'(d_rst), 32'(exp));
      check("hold_ready", 32'(d_ready), 32'(t == 28));
    end
    d_req_mask = 4'b0100;
    tick();
    d_req_valid = 1'b0;
    d_req_mask  = '0;
    check("hold_second_rst", 32'(d_rst), 32'hb);
    check("hold_second_busy", 32'(d_busy), 32'h1);
    wait_done(100);
    check("hold_final_rst", 32'(d_rst), 32'hf);

    // Minimal configuration: a request finishes in two cycles.
    s_req_valid = 1'b1;
    s_req_mask  = 1'b1;
    check("s_ready", 32'(s_ready), 32'h1);
    tick();
    s_req_valid = 1'b0;
    check("s_req_rst0", 32'(s_rst), 32'h0);
    check("s_req_busy0", 32'(s_busy), 32'h1);
    tick();
    check("s_req_rst1", 32'(s_rst), 32'h0);
    check("s_req_done1", 32'(s_done), 32'h0);
    tick();
    check("s_req_rst2", 32'(s_rst), 32'h1);
    check("s_req_done2", 32'(s_done), 32'h1);
    check("s_req_busy2", 32'(s_busy), 32'h0);
    tick();
    check("s_req_done3", 32'(s_done), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
